// File: rtl/clk_burst_ctrl_if.sv
// Configuration handshake into clk_burst_ctrl: half-period and burst length
// travel together and are taken on cfg_valid && cfg_ready.
interface clk_burst_ctrl_if #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_half;
  logic [BURST_W-1:0] cfg_burst;

  modport master (output cfg_valid, cfg_half, cfg_burst, input cfg_ready);
  modport slave  (input cfg_valid, cfg_half, cfg_burst, output cfg_ready);
endinterface

// File: rtl/clk_burst_ctrl.sv
// Programmable clock-pattern generator: 50% duty waveform of 2*half cycles,
// either continuous or a fixed number of pulses, always ending on a full period.
module clk_burst_ctrl #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  clk_burst_ctrl_if.slave    cfg,
  input  logic               start,
  input  logic               stop,
  output logic               clk_out,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W-1:0]   half_reg, half_n;
  logic [BURST_W-1:0] burst_reg, burst_n;
  logic [BURST_W-1:0] pulse_n;
  logic               stop_pend, stop_pend_n;
  logic               done_n;
  logic               cfg_accept;

  assign cfg.cfg_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign cfg_accept    = cfg.cfg_valid && (state == IDLE);

  // A config taken in the same cycle as start already shapes that run,
  // so the counter reload uses half_n rather than half_reg in IDLE.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    half_n      = half_reg;
    burst_n     = burst_reg;
    pulse_n     = pulse_cnt;
    stop_pend_n = stop_pend;
    done_n      = 1'b0;

    if (cfg_accept) begin
      half_n  = (cfg.cfg_half == '0) ? CNT_W'(1) : cfg.cfg_half;
      burst_n = cfg.cfg_burst;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_n     = HIGH;
          cnt_n       = half_n - CNT_W'(1);
          pulse_n     = '0;
          stop_pend_n = 1'b0;
        end
      end
      HIGH: begin
        if (stop) stop_pend_n = 1'b1;
        if (cnt == '0) begin
          state_n = LOW;
          cnt_n   = half_reg - CNT_W'(1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      LOW: begin
        if (stop) stop_pend_n = 1'b1;
        if (cnt == '0) begin
          // A stop arriving on the very last low cycle still ends this period.
          pulse_n = pulse_cnt + BURST_W'(1);
          if (stop_pend || stop || (burst_reg != '0 && pulse_n == burst_reg)) begin
            state_n     = IDLE;
            done_n      = 1'b1;
            stop_pend_n = 1'b0;
          end else begin
            state_n = HIGH;
            cnt_n   = half_reg - CNT_W'(1);
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // clk_out is a flop driven from the next state so the output never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      half_reg  <= CNT_W'(1);
      burst_reg <= '0;
      pulse_cnt <= '0;
      stop_pend <= 1'b0;
      done      <= 1'b0;
      clk_out   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      half_reg  <= half_n;
      burst_reg <= burst_n;
      pulse_cnt <= pulse_n;
      stop_pend <= stop_pend_n;
      done      <= done_n;
      clk_out   <= (state_n == HIGH);
    end
  end

endmodule

// File: tb/tb_clk_burst_ctrl.sv
// Self-checking bench for clk_burst_ctrl: a table of hand-derived vectors,
// directed corner sequences, and random traffic against a period-position model.
module tb_clk_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       clk_out;
  logic       busy;
  logic       done;
  logic [7:0] pulse_cnt;

  int errors = 0;
  int checks = 0;

  clk_burst_ctrl_if #(.CNT_W(8), .BURST_W(8)) cfg_if ();

  clk_burst_ctrl #(.CNT_W(8), .BURST_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg       (cfg_if),
    .start     (start),
    .stop      (stop),
    .clk_out   (clk_out),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a run is a position inside the current period (0..2h-1);
  // the output is high for the first h positions of every period.
  bit m_run;
  int m_pos;
  int m_h;
  int m_b;
  int m_pulses;
  bit m_stop_seen;
  bit m_done;

  task automatic modelStep(input bit v, input int h, input int b,
                           input bit s, input bit p, input bit r);
    if (r) begin
      m_run = 0; m_pos = 0; m_h = 1; m_b = 0;
      m_pulses = 0; m_stop_seen = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (!m_run) begin
      if (v) begin
        m_h = (h == 0) ? 1 : h;
        m_b = b;
      end
      if (s) begin
        m_run = 1; m_pos = 0; m_pulses = 0; m_stop_seen = 0;
      end
    end else begin
      if (p) m_stop_seen = 1;
      m_pos++;
      if (m_pos == 2 * m_h) begin
        m_pos = 0;
        m_pulses = (m_pulses + 1) % 256;
        if (m_stop_seen || (m_b != 0 && m_pulses == m_b)) begin
          m_run  = 0;
          m_done = 1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, and land 1ns after the edge.
  task automatic applyStimulus(input bit v, input int h, input int b,
                               input bit s, input bit p, input bit r);
    cfg_if.cfg_valid = v;
    cfg_if.cfg_half  = 8'(h);
    cfg_if.cfg_burst = 8'(b);
    start = s;
    stop  = p;
    rst   = r;
    modelStep(v, h, b, s, p, r);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output with the model for the current cycle.
  task automatic checkModel(input string tag);
    checkOutput({tag, " clk_out"},   int'(clk_out),   int'(m_run && (m_pos < m_h)));
    checkOutput({tag, " busy"},      int'(busy),      int'(m_run));
    checkOutput({tag, " cfg_ready"}, int'(cfg_if.cfg_ready), int'(!m_run));
    checkOutput({tag, " done"},      int'(done),      int'(m_done));
    checkOutput({tag, " pulse_cnt"}, int'(pulse_cnt), m_pulses);
  endtask

  // Run an already-started waveform until busy drops, with optional
  // mid-run stop/start/config pokes at given cycle numbers.
  task automatic runUntilIdle(input string tag, input int stopAt, input int startAt,
                              input int cfgAt, input int cfgHalf, input int maxCycles,
                              output int rises, output int dones, output int endK,
                              output int firstHigh);
    bit prev = 0;
    rises = 0; dones = 0; endK = -1; firstHigh = 0;
    for (int k = 1; k <= maxCycles; k++) begin
      checkModel(tag);
      if (clk_out && !prev) rises++;
      if (clk_out && rises == 1) firstHigh++;
      prev = clk_out;
      if (done) dones++;
      if (!busy) begin
        endK = k;
        break;
      end
      applyStimulus(k == cfgAt, cfgHalf, 1, k == startAt, k == stopAt, 0);
    end
    if (endK < 0) checkOutput({tag, " timeout"}, 0, 1);
  endtask

  typedef struct {
    bit v; int h; int b; bit s; bit p; bit r;
    bit e_clk; bit e_busy; bit e_done; bit e_rdy; int e_pc;
  } vec_t;

  vec_t vecs[15];

  // Fill the burst-of-three table, run it, then the directed and random phases.
  initial begin
    int rises, dones, endK, firstHigh;

    cfg_if.cfg_valid = 0; cfg_if.cfg_half = 0; cfg_if.cfg_burst = 0;
    start = 0; stop = 0; rst = 1;
    modelStep(0, 0, 0, 0, 0, 1);

    vecs[0]  = '{0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0};
    vecs[1]  = '{1, 2, 3, 1, 0, 0,  1, 1, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1};
    vecs[6]  = '{0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1};
    vecs[7]  = '{0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1};
    vecs[8]  = '{0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1};
    vecs[9]  = '{0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2};
    vecs[10] = '{0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2};
    vecs[11] = '{0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 2};
    vecs[12] = '{0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 2};
    vecs[13] = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 3};
    vecs[14] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 3};

    applyStimulus(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].v, vecs[i].h, vecs[i].b, vecs[i].s, vecs[i].p, vecs[i].r);
      checkOutput($sformatf("vec%0d clk_out", i),   int'(clk_out),   int'(vecs[i].e_clk));
      checkOutput($sformatf("vec%0d busy", i),      int'(busy),      int'(vecs[i].e_busy));
      checkOutput($sformatf("vec%0d done", i),      int'(done),      int'(vecs[i].e_done));
      checkOutput($sformatf("vec%0d cfg_ready", i), int'(cfg_if.cfg_ready), int'(vecs[i].e_rdy));
      checkOutput($sformatf("vec%0d pulse_cnt", i), int'(pulse_cnt), vecs[i].e_pc);
    end

    // half=0 behaves as half=1: two single-cycle high pulses.
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 2, 1, 0, 0);
    runUntilIdle("half0", 0, 0, 0, 0, 20, rises, dones, endK, firstHigh);
    checkOutput("half0 rises", rises, 2);
    checkOutput("half0 dones", dones, 1);
    checkOutput("half0 first high", firstHigh, 1);
    checkOutput("half0 end cycle", endK, 5);

    // Continuous half=3, stop in the middle of the 4th high phase.
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(1, 3, 0, 1, 0, 0);
    runUntilIdle("stop", 20, 0, 0, 0, 60, rises, dones, endK, firstHigh);
    checkOutput("stop end cycle", endK, 25);
    checkOutput("stop dones", dones, 1);
    checkOutput("stop pulse_cnt", int'(pulse_cnt), 4);
    checkOutput("stop rises", rises, 4);

    // Config offered mid-run is refused; offered again in IDLE it takes effect.
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(1, 2, 1, 1, 0, 0);
    checkOutput("busycfg ready", int'(cfg_if.cfg_ready), 0);
    runUntilIdle("busycfg", 0, 0, 2, 5, 20, rises, dones, endK, firstHigh);
    checkOutput("busycfg first high", firstHigh, 2);
    checkOutput("busycfg end cycle", endK, 5);
    applyStimulus(1, 5, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    runUntilIdle("newcfg", 0, 0, 0, 0, 30, rises, dones, endK, firstHigh);
    checkOutput("newcfg first high", firstHigh, 5);
    checkOutput("newcfg end cycle", endK, 11);

    // Stop alone in IDLE does nothing; start+stop+config together starts a run.
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("idlestop busy", int'(busy), 0);
    checkModel("idlestop");
    applyStimulus(1, 4, 2, 1, 1, 0);
    runUntilIdle("startstop", 0, 3, 0, 0, 40, rises, dones, endK, firstHigh);
    checkOutput("startstop first high", firstHigh, 4);
    checkOutput("startstop end cycle", endK, 17);
    checkOutput("startstop dones", dones, 1);
    checkOutput("startstop pulse_cnt", int'(pulse_cnt), 2);

    // Reset in the middle of a continuous run aborts without a done pulse.
    applyStimulus(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) idleCycle();
    checkOutput("rstmid pre clk_out", int'(clk_out), 1);
    checkOutput("rstmid pre pulse_cnt", int'(pulse_cnt), 2);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkModel("rstmid");
    checkOutput("rstmid clk_out", int'(clk_out), 0);
    checkOutput("rstmid busy", int'(busy), 0);
    checkOutput("rstmid cfg_ready", int'(cfg_if.cfg_ready), 1);
    checkOutput("rstmid pulse_cnt", int'(pulse_cnt), 0);
    idleCycle();
    checkOutput("rstmid done", int'(done), 0);

    // Continuous pulse counter wraps past 255 without ending the run.
    applyStimulus(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 512; i++) begin
      idleCycle();
      checkModel("wrap");
    end
    checkOutput("wrap pulse_cnt", int'(pulse_cnt), 0);
    checkOutput("wrap busy", int'(busy), 1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    runUntilIdle("wrapstop", 0, 0, 0, 0, 10, rises, dones, endK, firstHigh);
    checkOutput("wrapstop dones", dones, 1);

    // Random traffic, including occasional resets, against the model.
    applyStimulus(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
      checkModel("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
